// File: rtl/reset_seq.sv
// Board reset controller: conditions the reset sources, stretches each request,
// releases the downstream domains in order and keeps a sticky reset-cause register.
//
// state | meaning
// HOLD  | all domains held in reset, stretching after the last request clears
// STAGE | releasing domains one at a time, bit 0 first
// RUN   | all domains released, watchdog armed
module reset_seq #(
  parameter int DEB_CYC  = 4,
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 8,
  parameter int WDT_CYC  = 1000,
  parameter int NDOM     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sw_rst_n,
  input  logic            ext_rst_n,
  input  logic            soft_rst_n,
  input  logic            wdi,
  input  logic            wdt_en,
  input  logic            cause_clr,
  output logic [NDOM-1:0] dom_rst_n,
  output logic            wdt_rst_n,
  output logic [4:0]      rst_cause,
  output logic            busy
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int STEP_W = $clog2(STEP_CYC + 1);
  localparam int WDT_W  = $clog2(WDT_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(STEP_CYC - 1);
  localparam logic [WDT_W-1:0]  WDT_MAX   = WDT_W'(WDT_CYC - 1);
  localparam logic [NDOM-1:0]   DOM_FIRST = NDOM'(1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_STAGE,
    ST_RUN
  } state_t;

  state_t state_q, state_d;
  logic [1:0]        sw_sync_q, sw_sync_d;
  logic [1:0]        ext_sync_q, ext_sync_d;
  logic [2:0]        wdi_sync_q, wdi_sync_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d;
  logic [NDOM-1:0]   dom_q, dom_d;
  logic              busy_q, busy_d;
  logic              wdt_rst_q, wdt_rst_d;
  logic [4:0]        cause_q, cause_d;

  logic sw_low, sw_req, ext_req, soft_req, wdi_edge, wdt_exp, req;

  always_comb begin
    sw_sync_d  = {sw_sync_q[0], sw_rst_n};
    ext_sync_d = {ext_sync_q[0], ext_rst_n};
    wdi_sync_d = {wdi_sync_q[1:0], wdi};

    // sw_req fires on the DEB_CYC-th consecutive low sample, counting the current one
    sw_low   = ~sw_sync_q[1];
    sw_req   = sw_low && (deb_q == DEB_MAX);
    deb_d    = '0;
    if (sw_low) deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;

    ext_req  = ~ext_sync_q[1];
    soft_req = ~soft_rst_n;
    wdi_edge = wdi_sync_q[1] ^ wdi_sync_q[2];
    wdt_exp  = (state_q == ST_RUN) && wdt_en && !wdi_edge && (wdt_q == WDT_MAX);
    req      = sw_req | ext_req | soft_req | wdt_exp;

    state_d   = state_q;
    hold_d    = hold_q;
    step_d    = step_q;
    dom_d     = dom_q;
    busy_d    = busy_q;
    wdt_rst_d = ~wdt_exp;
    cause_d   = (cause_clr ? 5'b00000 : cause_q)
              | {wdt_exp, ext_req, soft_req, sw_req, 1'b0};

    wdt_d = '0;
    if ((state_q == ST_RUN) && wdt_en && !wdi_edge) wdt_d = wdt_q + 1'b1;

    if (req) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      step_d  = '0;
      dom_d   = '0;
      busy_d  = 1'b1;
      wdt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_MAX) begin
            hold_d = '0;
            step_d = '0;
            dom_d  = DOM_FIRST;
            if (NDOM == 1) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_STAGE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_STAGE: begin
          if (step_q == STEP_MAX) begin
            step_d = '0;
            dom_d  = (dom_q << 1) | DOM_FIRST;
            if (dom_d[NDOM-1]) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HOLD;
      sw_sync_q  <= '1;
      ext_sync_q <= '1;
      wdi_sync_q <= '1;
      deb_q      <= '0;
      hold_q     <= '0;
      step_q     <= '0;
      wdt_q      <= '0;
      dom_q      <= '0;
      busy_q     <= 1'b1;
      wdt_rst_q  <= 1'b1;
      cause_q    <= 5'b00001;
    end else begin
      state_q    <= state_d;
      sw_sync_q  <= sw_sync_d;
      ext_sync_q <= ext_sync_d;
      wdi_sync_q <= wdi_sync_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      step_q     <= step_d;
      wdt_q      <= wdt_d;
      dom_q      <= dom_d;
      busy_q     <= busy_d;
      wdt_rst_q  <= wdt_rst_d;
      cause_q    <= cause_d;
    end
  end

  assign dom_rst_n = dom_q;
  assign busy      = busy_q;
  assign wdt_rst_n = wdt_rst_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: expected output snapshots are queued with the
// edge they belong to and compared as the run reaches that edge.
module tb_reset_seq;

  logic       clk;
  logic       rst_n;
  logic       sw_rst_n;
  logic       ext_rst_n;
  logic       soft_rst_n;
  logic       wdi;
  logic       wdt_en;
  logic       cause_clr;
  logic [2:0] dom_rst_n;
  logic       wdt_rst_n;
  logic [4:0] rst_cause;
  logic       busy;

  reset_seq #(
    .DEB_CYC (4),
    .HOLD_CYC(16),
    .STEP_CYC(8),
    .WDT_CYC (1000),
    .NDOM    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_rst_n  (sw_rst_n),
    .ext_rst_n (ext_rst_n),
    .soft_rst_n(soft_rst_n),
    .wdi       (wdi),
    .wdt_en    (wdt_en),
    .cause_clr (cause_clr),
    .dom_rst_n (dom_rst_n),
    .wdt_rst_n (wdt_rst_n),
    .rst_cause (rst_cause),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [9:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // snapshot layout: {dom_rst_n, busy, wdt_rst_n, rst_cause}
  function automatic logic [9:0] pack(input logic [2:0] d, input logic b,
                                      input logic w, input logic [4:0] c);
    return {d, b, w, c};
  endfunction

  function automatic logic [9:0] obs();
    return {dom_rst_n, busy, wdt_rst_n, rst_cause};
  endfunction

  task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e);
    checks++;
    assert (o === e)
    else begin
      errors++;
      $error("FAIL %s observed dom/busy/wdt/cause=%b required=%b", tag, o, e);
    end
  endtask

  task automatic expect_at(input int at, input logic [2:0] d, input logic b,
                           input logic w, input logic [4:0] c, input string tag);
    exp_t e;
    e.at  = at;
    e.val = pack(d, b, w, c);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        check(e.tag, obs(), e.val);
      end
    end
  endtask

  int t0;

  initial begin
    rst_n      = 1'b0;
    sw_rst_n   = 1'b1;
    ext_rst_n  = 1'b1;
    soft_rst_n = 1'b1;
    wdi        = 1'b0;
    wdt_en     = 1'b0;
    cause_clr  = 1'b0;
    step(3);
    check("reset_values", obs(), pack(3'b000, 1'b1, 1'b1, 5'b00001));

    // power-on: edge t0+1 is HOLD count 0
    rst_n = 1'b1;
    t0 = cyc;
    expect_at(t0 + 15, 3'b000, 1'b1, 1'b1, 5'b00001, "por_e14");
    expect_at(t0 + 16, 3'b001, 1'b1, 1'b1, 5'b00001, "por_e15");
    expect_at(t0 + 23, 3'b001, 1'b1, 1'b1, 5'b00001, "por_e22");
    expect_at(t0 + 24, 3'b011, 1'b1, 1'b1, 5'b00001, "por_e23");
    expect_at(t0 + 31, 3'b011, 1'b1, 1'b1, 5'b00001, "por_e30");
    expect_at(t0 + 32, 3'b111, 1'b0, 1'b1, 5'b00001, "por_e31");
    step(40);

    // bouncing switch: never four consecutive low samples
    t0 = cyc;
    expect_at(t0 + 8,  3'b111, 1'b0, 1'b1, 5'b00001, "bounce_a");
    expect_at(t0 + 10, 3'b111, 1'b0, 1'b1, 5'b00001, "bounce_b");
    expect_at(t0 + 14, 3'b111, 1'b0, 1'b1, 5'b00001, "bounce_c");
    sw_rst_n = 1'b0; step(3);
    sw_rst_n = 1'b1; step(1);
    sw_rst_n = 1'b0; step(3);
    sw_rst_n = 1'b1; step(10);

    // genuine press: reset on edge 2+DEB_CYC, release 16 edges after sync high
    t0 = cyc;
    expect_at(t0 + 5,  3'b111, 1'b0, 1'b1, 5'b00001, "sw_e5");
    expect_at(t0 + 6,  3'b000, 1'b1, 1'b1, 5'b00011, "sw_e6");
    expect_at(t0 + 23, 3'b000, 1'b1, 1'b1, 5'b00011, "sw_rel_pre");
    expect_at(t0 + 24, 3'b001, 1'b1, 1'b1, 5'b00011, "sw_rel");
    expect_at(t0 + 32, 3'b011, 1'b1, 1'b1, 5'b00011, "sw_rel2");
    expect_at(t0 + 40, 3'b111, 1'b0, 1'b1, 5'b00011, "sw_run");
    sw_rst_n = 1'b0; step(6);
    sw_rst_n = 1'b1; step(40);

    // watchdog kicked every 500 cycles, then starved
    t0 = cyc;
    expect_at(t0 + 5000, 3'b111, 1'b0, 1'b1, 5'b00011, "wdt_kicked");
    expect_at(t0 + 5502, 3'b111, 1'b0, 1'b1, 5'b00011, "wdt_pre");
    expect_at(t0 + 5503, 3'b000, 1'b1, 1'b0, 5'b10011, "wdt_expire");
    expect_at(t0 + 5504, 3'b000, 1'b1, 1'b1, 5'b10011, "wdt_pulse_end");
    wdt_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wdi = ~wdi;
      step(500);
    end
    step(504);
    wdt_en = 1'b0;
    expect_at(t0 + 5535, 3'b111, 1'b0, 1'b1, 5'b10011, "wdt_rerun");
    step(35);

    // kick landing exactly in the expiry cycle suppresses the expiry
    t0 = cyc;
    expect_at(t0 + 1001, 3'b111, 1'b0, 1'b1, 5'b10011, "wdt_edge_wins");
    wdt_en = 1'b1;
    step(997);
    wdi = ~wdi;
    step(4);
    wdt_en = 1'b0;
    step(2);

    // soft request, then another one while dom_rst_n=011
    t0 = cyc;
    expect_at(t0 + 1,  3'b000, 1'b1, 1'b1, 5'b10111, "soft_e0");
    expect_at(t0 + 17, 3'b001, 1'b1, 1'b1, 5'b10111, "soft_rel0");
    expect_at(t0 + 25, 3'b011, 1'b1, 1'b1, 5'b10111, "soft_rel1");
    expect_at(t0 + 28, 3'b011, 1'b1, 1'b1, 5'b10111, "mid_pre");
    soft_rst_n = 1'b0; step(1);
    soft_rst_n = 1'b1; step(27);
    expect_at(t0 + 29, 3'b000, 1'b1, 1'b1, 5'b10111, "mid_soft");
    expect_at(t0 + 44, 3'b000, 1'b1, 1'b1, 5'b10111, "mid_e14");
    expect_at(t0 + 45, 3'b001, 1'b1, 1'b1, 5'b10111, "mid_e15");
    expect_at(t0 + 52, 3'b001, 1'b1, 1'b1, 5'b10111, "mid_e22");
    expect_at(t0 + 53, 3'b011, 1'b1, 1'b1, 5'b10111, "mid_e23");
    expect_at(t0 + 60, 3'b011, 1'b1, 1'b1, 5'b10111, "mid_e30");
    expect_at(t0 + 61, 3'b111, 1'b0, 1'b1, 5'b10111, "mid_e31");
    soft_rst_n = 1'b0; step(1);
    soft_rst_n = 1'b1; step(35);

    // cause_clr alone
    t0 = cyc;
    expect_at(t0 + 1, 3'b111, 1'b0, 1'b1, 5'b00000, "clr_alone");
    cause_clr = 1'b1; step(1);
    cause_clr = 1'b0; step(2);

    // ext and soft asserted together; ext arrives through its synchronizer
    t0 = cyc;
    expect_at(t0 + 1,  3'b000, 1'b1, 1'b1, 5'b00100, "sim_soft");
    expect_at(t0 + 2,  3'b000, 1'b1, 1'b1, 5'b00100, "sim_sync");
    expect_at(t0 + 3,  3'b000, 1'b1, 1'b1, 5'b01100, "sim_both");
    expect_at(t0 + 20, 3'b000, 1'b1, 1'b1, 5'b01100, "sim_rel_pre");
    expect_at(t0 + 21, 3'b001, 1'b1, 1'b1, 5'b01100, "sim_rel");
    expect_at(t0 + 37, 3'b111, 1'b0, 1'b1, 5'b01100, "sim_run");
    ext_rst_n  = 1'b0;
    soft_rst_n = 1'b0;
    step(3);
    ext_rst_n  = 1'b1;
    soft_rst_n = 1'b1;
    step(40);

    // clear and set in the same cycle: the set wins
    t0 = cyc;
    expect_at(t0 + 1,  3'b000, 1'b1, 1'b1, 5'b00100, "clr_and_soft");
    expect_at(t0 + 17, 3'b001, 1'b1, 1'b1, 5'b00100, "clr_soft_rel");
    soft_rst_n = 1'b0;
    cause_clr  = 1'b1;
    step(1);
    soft_rst_n = 1'b1;
    cause_clr  = 1'b0;
    step(19);

    // power reset mid-STAGE takes effect without a clock edge
    rst_n = 1'b0;
    #2;
    check("por_async", obs(), pack(3'b000, 1'b1, 1'b1, 5'b00001));
    step(2);
    rst_n = 1'b1;
    t0 = cyc;
    expect_at(t0 + 16, 3'b001, 1'b1, 1'b1, 5'b00001, "por2_e15");
    expect_at(t0 + 32, 3'b111, 1'b0, 1'b1, 5'b00001, "por2_e31");
    step(35);

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d pending required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
